alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_core.sv | 44 ++++
 rtl/alu_seq.sv | 134 +++++++++++++
 tb/tb_alu_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential Hack-style ALU.
// Holds the FSM state enum, the mode encoding and the flag bundle.
package alu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  localparam logic MODE_HACK = 1'b0;
  localparam logic MODE_MUL  = 1'b1;

  typedef struct packed {
    logic zr;
    logic ng;
    logic cr;
    logic ov;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational Hack datapath: operand preprocessing, add/AND, carry and
// overflow (taken before output negation), and the final `no` inversion.
module alu_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] xt,
  output logic [WIDTH-1:0] yt,
  output logic [WIDTH-1:0] res,
  output logic             cr,
  output logic             ov
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;

  // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
  always_comb begin
    xt = zx ? '0 : x;
    if (nx) xt = ~xt;
    yt = zy ? '0 : y;
    if (ny) yt = ~yt;

    sum = {1'b0, xt} + {1'b0, yt};
    r   = xt & yt;
    cr  = 1'b0;
    ov  = 1'b0;
    if (f) begin
      r  = sum[WIDTH-1:0];
      cr = sum[WIDTH];
      ov = (xt[WIDTH-1] == yt[WIDTH-1]) && (sum[WIDTH-1] != xt[WIDTH-1]);
    end

    res = no ? ~r : r;
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle Hack ops, WIDTH-cycle shift-add multiply,
// and a valid/ready output register that holds results under back-pressure.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cr,
  output logic             ov
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, mcand, prod;
  logic [WIDTH-1:0]   mplier;
  logic               no_q;

  logic [WIDTH-1:0]   xt, yt, hack_res, mul_res, load_val;
  logic               hack_cr, hack_ov;
  logic               accept, last, load;
  flags_t             load_flags, flags_q;
  logic [WIDTH-1:0]   out_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x   (x),
    .y   (y),
    .zx  (zx),
    .nx  (nx),
    .zy  (zy),
    .ny  (ny),
    .f   (f),
    .no  (no),
    .xt  (xt),
    .yt  (yt),
    .res (hack_res),
    .cr  (hack_cr),
    .ov  (hack_ov)
  );

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (state == MUL) && (cnt == CNT_W'(WIDTH - 1));
  assign load     = (accept && (mode == MODE_HACK)) || last;

  // The last iteration's partial product is folded in combinationally so the
  // result loads on the same edge the iteration completes.
  always_comb begin
    prod       = acc + (mplier[0] ? mcand : '0);
    mul_res    = no_q ? ~prod[WIDTH-1:0] : prod[WIDTH-1:0];
    load_val   = last ? mul_res : hack_res;
    load_flags = '0;
    load_flags.zr = (load_val == '0);
    load_flags.ng = load_val[WIDTH-1];
    load_flags.cr = last ? 1'b0 : hack_cr;
    load_flags.ov = last ? (|prod[2*WIDTH-1:WIDTH]) : hack_ov;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (mode == MODE_MUL)) state_nxt = MUL;
      MUL:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      no_q   <= 1'b0;
    end else if (accept && (mode == MODE_MUL)) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, xt};
      mplier <= yt;
      no_q   <= no;
    end else if (state == MUL) begin
      cnt    <= last ? '0 : cnt + CNT_W'(1);
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      flags_q   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_q     <= load_val;
      flags_q   <= load_flags;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out = out_q;
  assign zr  = flags_q.zr;
  assign ng  = flags_q.ng;
  assign cr  = flags_q.cr;
  assign ov  = flags_q.ov;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus a randomized
// phase scored against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;
  localparam longint unsigned MASK = (64'd1 << W) - 1;

  typedef struct {
    logic [W-1:0] out;
    logic         zr, ng, cr, ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, mode = 1'b0;
  logic zx = 0, nx = 0, zy = 0, ny = 0, f = 0, no = 0;
  logic [W-1:0] x = '0, y = '0;
  logic in_ready, out_valid, zr, ng, cr, ov;
  logic [W-1:0] out;

  logic in_valid_w = 1'b0;
  logic [7:0]  x8 = '0, y8 = '0, out8;
  logic [31:0] x32 = '0, y32 = '0, out32;
  logic in_ready8, out_valid8, zr8, ng8, cr8, ov8;
  logic in_ready32, out_valid32, zr32, ng32, cr32, ov32;

  int total = 0;
  int bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zr(zr), .ng(ng), .cr(cr), .ov(ov)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready8),
    .x(x8), .y(y8), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mode(mode),
    .out_valid(out_valid8), .out_ready(out_ready), .out(out8),
    .zr(zr8), .ng(ng8), .cr(cr8), .ov(ov8)
  );

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready32),
    .x(x32), .y(y32), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mode(mode),
    .out_valid(out_valid32), .out_ready(out_ready), .out(out32),
    .zr(zr32), .ng(ng32), .cr(cr32), .ov(ov32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: two's-complement arithmetic on integers, not bit-level logic.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] ya,
                                 input logic zxa, input logic nxa, input logic zya,
                                 input logic nya, input logic fa, input logic noa,
                                 input logic ma);
    exp_t e;
    longint unsigned xt, yt, r, p;
    longint sx, sy, s;
    xt = zxa ? 0 : longint'(xa);
    if (nxa) xt = ~xt & MASK;
    yt = zya ? 0 : longint'(ya);
    if (nya) yt = ~yt & MASK;
    e.cr = 1'b0;
    e.ov = 1'b0;
    if (ma) begin
      p = xt * yt;
      r = p & MASK;
      e.ov = (p > MASK);
    end else if (fa) begin
      p = xt + yt;
      r = p & MASK;
      e.cr = (p > MASK);
      sx = (xt > (MASK >> 1)) ? longint'(xt) - longint'(MASK + 1) : longint'(xt);
      sy = (yt > (MASK >> 1)) ? longint'(yt) - longint'(MASK + 1) : longint'(yt);
      s = sx + sy;
      e.ov = (s > longint'(MASK >> 1)) || (s < -longint'((MASK >> 1) + 1));
    end else begin
      r = xt & yt;
    end
    if (noa) r = ~r & MASK;
    e.out = W'(r);
    e.zr = (r == 0);
    e.ng = (r > (MASK >> 1));
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic set_ctrl(input logic [5:0] c, input logic m);
    {zx, nx, zy, ny, f, no} = c;
    mode = m;
  endtask

  task automatic settle(input int n);
    in_valid = 1'b0;
    in_valid_w = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Counts low-phase samples without out_valid after an accept edge.
  task automatic wait_mul(output int n, output int leak);
    n = 0;
    leak = 0;
    do begin
      @(negedge clk);
      #1;
      if (!out_valid) begin
        n++;
        if (in_ready) leak++;
      end
    end while (!out_valid && n < 40);
    check("mul_timeout", out_valid, 1'b1);
  endtask

  initial begin
    int n, leak, seen;
    logic [W-1:0] held;
    logic [3:0] held_f;
    exp_t e;
    logic hold_pending;
    logic [W-1:0] prev_out;
    logic [3:0] prev_f;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);

    // Reset mid-multiply: result must be discarded.
    @(negedge clk);
    set_ctrl(6'b000000, 1'b1);
    x = 16'd3; y = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", {out, zr, ng, cr, ov}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    seen = 0;
    repeat (24) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("rst_no_stale", seen, 0);

    // Back-to-back Hack adds.
    set_ctrl(6'b000010, 1'b0);
    x = 16'h7FFF; y = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("hack_in_ready", in_ready, 1'b1);
    @(negedge clk);
    x = 16'hFFFF; y = 16'h0001;
    #1;
    check("hack1_valid", out_valid, 1'b1);
    check("hack1_out", out, 16'h8000);
    check("hack1_flags", {zr, ng, cr, ov}, 4'b0101);
    check("hack1_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("hack2_valid", out_valid, 1'b1);
    check("hack2_out", out, 16'h0000);
    check("hack2_flags", {zr, ng, cr, ov}, 4'b1010);
    @(negedge clk);
    #1;
    check("hack_drained", out_valid, 1'b0);

    // Multiply 300*300 with the consumer stalled, then back-pressure.
    set_ctrl(6'b000000, 1'b1);
    x = 16'd300; y = 16'd300; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    x = 16'hAAAA; y = 16'h5555; set_ctrl(6'b111111, 1'b0);
    wait_mul(n, leak);
    check("mul_latency", n, W);
    check("mul_busy", leak, 0);
    check("mul_out", out, 16'h5F90);
    check("mul_flags", {zr, ng, cr, ov}, 4'b0001);
    held = out;
    held_f = {zr, ng, cr, ov};
    set_ctrl(6'b000010, 1'b0);
    x = 16'h1234; y = 16'h0001; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_valid", out_valid, 1'b1);
      check("bp_out", {out, zr, ng, cr, ov}, {held, held_f});
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_new_valid", out_valid, 1'b1);
    check("bp_new_out", out, 16'h1235);
    check("bp_new_flags", {zr, ng, cr, ov}, 4'b0000);
    settle(2);

    // Control bits at three widths: ~(-1 + 0) = 0.
    set_ctrl(6'b111011, 1'b0);
    x = W'($urandom); y = W'($urandom);
    x8 = 8'($urandom); y8 = 8'($urandom);
    x32 = $urandom; y32 = $urandom;
    in_valid = 1'b1; in_valid_w = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_valid_w = 1'b0;
    #1;
    check("ctl16", {out_valid, out, zr, ng}, {1'b1, 16'h0, 1'b1, 1'b0});
    check("ctl8", {out_valid8, out8, zr8, ng8}, {1'b1, 8'h0, 1'b1, 1'b0});
    check("ctl32", {out_valid32, out32, zr32, ng32}, {1'b1, 32'h0, 1'b1, 1'b0});
    settle(2);

    // Multiply with negated result.
    set_ctrl(6'b000001, 1'b1);
    x = 16'd0; y = 16'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_mul(n, leak);
    check("mulneg_latency", n, W);
    check("mulneg_out", out, 16'hFFFF);
    check("mulneg_flags", {zr, ng, cr, ov}, 4'b0100);
    settle(2);

    // Randomized traffic against the reference model.
    hold_pending = 1'b0;
    prev_out = '0;
    prev_f = '0;
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_ctrl(6'($urandom), ($urandom_range(0, 5) == 0));
      x = pick();
      y = pick();
      #1;
      if (hold_pending)
        check("rnd_hold", {out_valid, out, zr, ng, cr, ov}, {1'b1, prev_out, prev_f});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rnd_spurious", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("rnd_out", out, e.out);
          check("rnd_flags", {zr, ng, cr, ov}, {e.zr, e.ng, e.cr, e.ov});
        end
      end
      if (in_valid && in_ready) q.push_back(model(x, y, zx, nx, zy, ny, f, no, mode));
      hold_pending = out_valid && !out_ready;
      prev_out = out;
      prev_f = {zr, ng, cr, ov};
      @(negedge clk);
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        check("drain_out", out, e.out);
        check("drain_flags", {zr, ng, cr, ov}, {e.zr, e.ng, e.cr, e.ov});
      end
      @(negedge clk);
    end
    check("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
